// File: rtl/seq_divider3.sv
`default_nettype none
// ============================================================================
// Module   : seq_divider3
// Brief    : 4-bit by 3-bit unsigned divider using repeated subtraction,
//            with divide-by-zero flag and 7-segment display of the quotient.
// Revision : 1.0 - initial release
// ============================================================================
module seq_divider3 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] dividend,
    input  logic [2:0] divisor,
    input  logic       start,
    output logic [3:0] quotient,
    output logic [2:0] remainder,
    output logic       busy,
    output logic       done,
    output logic       div_err,
    output logic [1:7] leds
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [3:0] r_w;
    logic [2:0] r_d;
    logic [3:0] r_qw;
    logic       w_ge;
    logic       w_dzero;

    assign w_dzero = (r_d == 3'd0);
    assign w_ge    = (r_w >= {1'b0, r_d});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_RUN;
            S_RUN:   if (w_dzero || !w_ge) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Operands are captured only at acceptance; results update only on completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_w       <= 4'd0;
            r_d       <= 3'd0;
            r_qw      <= 4'd0;
            quotient  <= 4'd0;
            remainder <= 3'd0;
            div_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_w     <= dividend;
                        r_d     <= divisor;
                        r_qw    <= 4'd0;
                        div_err <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (w_dzero) begin
                        div_err   <= 1'b1;
                        quotient  <= 4'hF;
                        remainder <= 3'd0;
                    end else if (w_ge) begin
                        r_w  <= r_w - {1'b0, r_d};
                        r_qw <= r_qw + 4'd1;
                    end else begin
                        quotient  <= r_qw;
                        remainder <= r_w[2:0];
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (r_state == S_RUN);
    assign done = (r_state == S_DONE);

    hex7seg u_hex7seg (
        .hex  (quotient),
        .leds (leds)
    );

endmodule

// ============================================================================
// Module   : hex7seg
// Brief    : Hex digit to active-high segments, leds[1:7] = segments a..g.
// Revision : 1.0 - initial release
// ============================================================================
module hex7seg (
    input  logic [3:0] hex,
    output logic [1:7] leds
);

    always_comb begin
        leds = 7'b0000000;
        case (hex)
            4'h0: leds = 7'b1111110;
            4'h1: leds = 7'b0110000;
            4'h2: leds = 7'b1101101;
            4'h3: leds = 7'b1111001;
            4'h4: leds = 7'b0110011;
            4'h5: leds = 7'b1011011;
            4'h6: leds = 7'b1011111;
            4'h7: leds = 7'b1110000;
            4'h8: leds = 7'b1111111;
            4'h9: leds = 7'b1111011;
            4'hA: leds = 7'b1110111;
            4'hB: leds = 7'b0011111;
            4'hC: leds = 7'b1001110;
            4'hD: leds = 7'b0111101;
            4'hE: leds = 7'b1001111;
            4'hF: leds = 7'b1000111;
            default: leds = 7'b0000000;
        endcase
    end

endmodule
`default_nettype wire

// File: doc/seq_divider3.md
SEQ_DIVIDER3 -- requirements
Module: seq_divider3

Interface
REQ-001 Parameters: none; all widths are fixed as listed below.
REQ-002 The block SHALL use a single clock; reset SHALL be asynchronous and active-low.
REQ-003 Clock  input  1  system clock; all state changes on its rising edge.
REQ-004 Reset  input  1  asynchronous, active-low; 0 forces the reset state immediately.
REQ-005 Dividend  input  4  unsigned dividend, 0..15.
REQ-006 Divisor  input  3  unsigned divisor, 0..7.
REQ-007 Start  input  1  request pulse or level; sampled only in IDLE.
REQ-008 Quotient  output  4  registered quotient of the last completed operation.
REQ-009 Remainder  output  3  registered remainder of the last completed operation.
REQ-010 Busy  output  1  high while the operation is in state RUN.
REQ-011 Done  output  1  single-cycle completion strobe.
REQ-012 DivErr  output  1  divide-by-zero flag; held until the next accepted Start.
REQ-013 leds  output  [1:7]  Quotient driven through the team's existing hex7seg decoder.

Function
REQ-014 The block SHALL divide by repeated subtraction; it is the inverse of the 3-bit accumulator/adder path.
REQ-015 FSM states SHALL be IDLE, RUN and DONE, with IDLE as the reset state.
REQ-016 Acceptance: on an edge in IDLE with Start=1 -> W(4b)<=Dividend, D(3b)<=Divisor, Qw<=0, DivErr<=0, state<=RUN.
REQ-017 Dividend and Divisor SHALL be sampled only at acceptance; later input changes have no effect on the running operation.
REQ-018 RUN, D==0: next edge -> DivErr<=1, Quotient<=4'hF, Remainder<=0, state<=DONE.
REQ-019 RUN, D!=0, W>=D (4-bit compare, D zero-extended): next edge -> W<=W-D, Qw<=Qw+1, stay in RUN.
REQ-020 RUN, D!=0, W<D: next edge -> Quotient<=Qw, Remainder<=W[2:0], state<=DONE.
REQ-021 Remainder SHALL always be less than D, so W[2:0] is exact.
REQ-022 Qw SHALL never wrap; its maximum is 15 (15/1).
REQ-023 DONE SHALL last exactly one cycle: Done=1, then unconditionally -> IDLE.
REQ-024 Start SHALL be ignored in RUN and DONE; no queuing.
REQ-025 Latency: Done high in the cycle following edge N+1 after the acceptance edge, where N is the quotient; divide-by-zero takes 1 edge.
REQ-026 Busy SHALL be 1 exactly in RUN and 0 in IDLE and DONE.
REQ-027 Quotient, Remainder and DivErr SHALL hold their values from entering DONE until the next completion or reset.
REQ-028 Dividend=0 with Divisor!=0 SHALL complete on the first RUN edge with Quotient=0 and Remainder=0.

Reset
REQ-029 While Reset=0: state=IDLE, W=0, D=0, Qw=0, Quotient=0, Remainder=0, Busy=0, Done=0, DivErr=0, leds=hex7seg(0).
REQ-030 Reset asserted mid-RUN SHALL abort the operation immediately with no Done pulse.
REQ-031 After Reset rises, the first Start SHALL be accepted normally.

Verification
REQ-032 14/3: Start 1 cycle -> Busy for 5 cycles; Done 5 edges after acceptance; Quotient=4, Remainder=2, DivErr=0.
REQ-033 15/1 -> Quotient=15, Remainder=0, Done 16 edges after acceptance; 7/7 -> Quotient=1, Remainder=0.
REQ-034 5/0 -> one edge later Done=1, DivErr=1, Quotient=F, Remainder=0; a following 6/4 clears DivErr and gives Quotient=1, Remainder=2.
REQ-035 Start held high throughout, with Dividend/Divisor changed during RUN -> result uses the values sampled at acceptance; re-acceptance occurs only after DONE->IDLE.
REQ-036 Reset pulsed low during RUN of 12/1 -> outputs 0 immediately, no Done pulse; a subsequent 9/2 -> Quotient=4, Remainder=1.
REQ-037 0/5 -> Done 1 edge after acceptance, Quotient=0, Remainder=0; leds match hex7seg of Quotient in every case.
